// File: rtl/sat_ctrl_pkg.sv
// Shared definitions for the saturating add/subtract arbiter.
// - op field bit positions inside each requester's 3-bit op word
// - constant functions producing signed max/min patterns for a given width
// - result struct type for code that wants to carry {data, carry, sat} as one bundle
package sat_ctrl_pkg;

  // Bit positions inside a requester's op word {sat, tc, addsub}.
  localparam int unsigned OP_ADDSUB = 0;
  localparam int unsigned OP_TC     = 1;
  localparam int unsigned OP_SAT    = 2;
  localparam int unsigned OP_W      = 3;

  // Widest datapath the helper functions and result struct support.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             carry;
    logic             sat;
  } sat_res_t;

  // 0111..1 in the low `width` bits.
  function automatic logic [MAX_W-1:0] signed_max(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  // 1000..0 in the low `width` bits.
  function automatic logic [MAX_W-1:0] signed_min(input int unsigned width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sat_addsub_core.sv
// Combinational saturating adder/subtractor.
// Ports:
//   a, b     operands (WIDTH bits)
//   addsub   1 = a - b, 0 = a + b
//   tc       1 = operands are two's complement, 0 = unsigned
//   sat      1 = clamp on overflow, 0 = wrap
//   data     result (clamped or wrapped)
//   carry    adder carry-out; 0 for unsigned saturating ops; sign-corrected when tc=1
//   sat_hit  a clamp was applied
module sat_addsub_core
  import sat_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             addsub,
  input  logic             tc,
  input  logic             sat,
  output logic [WIDTH-1:0] data,
  output logic             carry,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] SMax = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMin = WIDTH'(signed_min(WIDTH));

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry_out;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;
  logic             ovf_s;
  logic             ovf_u;

  always_comb begin
    // Subtract as a + ~b + 1.
    b_eff     = addsub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, addsub};
    carry_out = sum[WIDTH];
    a_msb     = a[WIDTH-1];
    b_msb     = b[WIDTH-1];
    r_msb     = sum[WIDTH-1];

    // Signed overflow: add needs like signs, subtract needs unlike signs, and the
    // result sign must disagree with A.
    if (addsub) begin
      ovf_s = (a_msb != b_msb) && (r_msb != a_msb);
      ovf_u = !carry_out;  // no carry out of a + ~b + 1 means a < b
    end else begin
      ovf_s = (a_msb == b_msb) && (r_msb != a_msb);
      ovf_u = carry_out;
    end

    data    = sum[WIDTH-1:0];
    sat_hit = 1'b0;
    if (sat) begin
      if (tc && ovf_s) begin
        data    = a_msb ? SMin : SMax;
        sat_hit = 1'b1;
      end else if (!tc && ovf_u) begin
        data    = addsub ? '0 : '1;
        sat_hit = 1'b1;
      end
    end

    if (sat && !tc) begin
      carry = 1'b0;
    end else if (tc) begin
      carry = carry_out ^ (a_msb ^ b_msb);
    end else begin
      carry = carry_out;
    end
  end

endmodule

// File: rtl/sat_addsub_arb.sv
// Round-robin arbiter in front of one shared saturating add/subtract datapath.
// One request is granted per cycle into the issue stage (S1), computed by
// sat_addsub_core, and registered with its requester tag into the result stage
// (S2) that drives res_*. A sticky per-requester flag records saturation events.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (at most one ready bit high)
//   req_a, req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op                packed {sat, tc, addsub}, requester i at [i*3 +: 3]
//   res_valid/res_ready   result handshake
//   res_data, res_id      result value and originating requester
//   res_carry, res_sat    carry/borrow and clamp-applied status
//   sat_flag, sat_clr     sticky saturation flags and their per-bit clears
module sat_addsub_arb
  import sat_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     res_carry,
  output logic                     res_sat,
  output logic [NUM_REQ-1:0]       sat_flag,
  input  logic [NUM_REQ-1:0]       sat_clr
);

  // Issue stage.
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [OP_W-1:0]  s1_op_q;
  logic [ID_W-1:0]  s1_id_q;

  // Result stage.
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [ID_W-1:0]  res_id_q;
  logic             res_carry_q;
  logic             res_sat_q;

  logic [NUM_REQ-1:0] sat_flag_q;
  logic [NUM_REQ-1:0] sat_flag_d;
  logic [NUM_REQ-1:0] flag_set;

  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  rr_d;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             accept;
  logic             s1_free;
  logic             s2_free;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OP_W-1:0]  sel_op;

  logic [WIDTH-1:0] core_data;
  logic             core_carry;
  logic             core_sat_hit;

  assign s2_free = !res_valid_q || res_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // Round-robin search: first pass covers indices at or above the pointer, the
  // second pass covers the wrapped-around indices below it.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= rr_q)) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    accept    = found && s1_free && !rst;
    if (found && !rst) begin
      req_ready[win] = s1_free;
    end
    rr_d = rr_q;
    if (accept) begin
      rr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  sat_addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a       (s1_a_q),
    .b       (s1_b_q),
    .addsub  (s1_op_q[OP_ADDSUB]),
    .tc      (s1_op_q[OP_TC]),
    .sat     (s1_op_q[OP_SAT]),
    .data    (core_data),
    .carry   (core_carry),
    .sat_hit (core_sat_hit)
  );

  // Set happens on the edge the clamped result enters S2; set beats clear.
  always_comb begin
    flag_set = '0;
    if (s2_free && s1_valid_q && core_sat_hit) begin
      flag_set[s1_id_q] = 1'b1;
    end
    sat_flag_d = (sat_flag_q & ~sat_clr) | flag_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_carry_q <= 1'b0;
      res_sat_q   <= 1'b0;
      sat_flag_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      sat_flag_q <= sat_flag_d;
      if (s1_free) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_a_q  <= sel_a;
          s1_b_q  <= sel_b;
          s1_op_q <= sel_op;
          s1_id_q <= win;
        end
      end
      if (s2_free) begin
        res_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_data_q  <= core_data;
          res_id_q    <= s1_id_q;
          res_carry_q <= core_carry;
          res_sat_q   <= core_sat_hit;
        end
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_carry = res_carry_q;
  assign res_sat   = res_sat_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_sat_addsub_arb.sv
// Self-checking bench for sat_addsub_arb (WIDTH=8, NUM_REQ=4).
module tb_sat_addsub_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [11:0] req_op;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        res_carry;
  logic        res_sat;
  logic [3:0]  sat_flag;
  logic [3:0]  sat_clr;

  int errors = 0;
  int checks = 0;

  sat_addsub_arb #(
    .WIDTH   (8),
    .NUM_REQ (4),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_carry (res_carry),
    .res_sat   (res_sat),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {sat, carry, data} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    int ua, ub, sa, sb, r;
    logic c, s;
    logic [7:0] d;
    ua = int'(a);
    ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    c  = op[0] ? (ua >= ub) : ((ua + ub) > 255);
    s  = 1'b0;
    if (op[2] && op[1]) begin
      r = op[0] ? sa - sb : sa + sb;
      if (r > 127) begin r = 127; s = 1'b1; end
      if (r < -128) begin r = -128; s = 1'b1; end
    end else if (op[2]) begin
      r = op[0] ? ua - ub : ua + ub;
      if (r > 255) begin r = 255; s = 1'b1; end
      if (r < 0) begin r = 0; s = 1'b1; end
    end else begin
      r = op[0] ? ua - ub : ua + ub;
    end
    d = r[7:0];
    if (op[2] && !op[1]) c = 1'b0;
    else if (op[1]) c = c ^ a[7] ^ b[7];
    return {s, c, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    sat_clr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents one request and returns after the edge that accepts it.
  task automatic send_one(input int r, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, output bit ok);
    ok = 1'b0;
    req_a[r*8 +: 8]  = a;
    req_b[r*8 +: 8]  = b;
    req_op[r*3 +: 3] = op;
    req_valid = 4'(1 << r);
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (req_ready[r]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b1;
    sat_clr = '0;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000)
      begin errors++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    checks++;
    if ({res_valid, res_data, res_id, res_carry, res_sat, sat_flag} !== 16'h0)
      begin errors++; $display("FAIL reset_outputs got v=%b d=%h id=%0d c=%b s=%b f=%b want zeros",
                               res_valid, res_data, res_id, res_carry, res_sat, sat_flag); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001)
      begin errors++; $display("FAIL reset_first_grant got=%b want=0001", req_ready); end
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_signed_sat();
    bit ok;
    do_reset();
    send_one(0, 8'd100, 8'd50, 3'b110, ok);
    wait_res(ok);
    checks++;
    if (!ok || res_data !== 8'd127 || res_sat !== 1'b1 || res_id !== 2'd0)
      begin errors++; $display("FAIL signed_add_clamp got v=%b d=%0d s=%b id=%0d want d=127 s=1 id=0",
                               res_valid, res_data, res_sat, res_id); end
    checks++;
    if (sat_flag[0] !== 1'b1)
      begin errors++; $display("FAIL signed_flag0 got=%b want=1", sat_flag[0]); end
    send_one(0, 8'h9C, 8'd50, 3'b111, ok);
    wait_res(ok);
    checks++;
    if (!ok || res_data !== 8'h80 || res_sat !== 1'b1 || res_carry !== 1'b0)
      begin errors++; $display("FAIL signed_sub_clamp got v=%b d=%h s=%b c=%b want d=80 s=1 c=0",
                               res_valid, res_data, res_sat, res_carry); end
    tick();
  endtask

  task automatic test_unsigned();
    bit ok;
    do_reset();
    send_one(2, 8'd200, 8'd100, 3'b100, ok);
    wait_res(ok);
    checks++;
    if (!ok || res_data !== 8'd255 || res_carry !== 1'b0 || res_sat !== 1'b1 || res_id !== 2'd2)
      begin errors++; $display("FAIL usat_add got d=%0d c=%b s=%b id=%0d want 255 0 1 2",
                               res_data, res_carry, res_sat, res_id); end
    send_one(2, 8'd10, 8'd20, 3'b101, ok);
    wait_res(ok);
    checks++;
    if (!ok || res_data !== 8'd0 || res_sat !== 1'b1)
      begin errors++; $display("FAIL usat_sub got d=%0d s=%b want 0 1", res_data, res_sat); end
    send_one(3, 8'd200, 8'd100, 3'b000, ok);
    wait_res(ok);
    checks++;
    if (!ok || res_data !== 8'd44 || res_carry !== 1'b1 || res_sat !== 1'b0)
      begin errors++; $display("FAIL wrap_add got d=%0d c=%b s=%b want 44 1 0",
                               res_data, res_carry, res_sat); end
    send_one(3, 8'd10, 8'd20, 3'b001, ok);
    wait_res(ok);
    checks++;
    if (!ok || res_data !== 8'hF6 || res_carry !== 1'b0 || res_sat !== 1'b0)
      begin errors++; $display("FAIL wrap_sub got d=%h c=%b s=%b want f6 0 0",
                               res_data, res_carry, res_sat); end
    tick();
  endtask

  task automatic test_round_robin();
    int got;
    logic [7:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 8'(11 * i);
      req_a[i*8 +: 8]  = a;
      req_b[i*8 +: 8]  = 8'(i + 1);
      req_op[i*3 +: 3] = 3'b000;
    end
    got = 0;
    for (int c = 0; c < 16; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        checks++;
        if (req_ready !== 4'(1 << (c % 4)))
          begin errors++; $display("FAIL rr_grant cycle=%0d got=%b want=%b", c, req_ready,
                                   4'(1 << (c % 4))); end
      end
      if (res_valid) begin
        checks++;
        if (res_id !== 2'(got % 4) || res_data !== 8'(12 * (got % 4) + 1))
          begin errors++; $display("FAIL rr_result n=%0d got id=%0d d=%0d want id=%0d d=%0d",
                                   got, res_id, res_data, got % 4, 12 * (got % 4) + 1); end
        got++;
      end else if (got > 0 && got < 8) begin
        checks++;
        errors++;
        $display("FAIL rr_bubble after %0d results", got);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got !== 8)
      begin errors++; $display("FAIL rr_count got=%0d want=8", got); end
  endtask

  task automatic test_backpressure();
    logic [3:0] v;
    do_reset();
    res_ready = 1'b0;
    req_a[16 +: 8] = 8'd30;  req_b[16 +: 8] = 8'd12; req_op[6 +: 3] = 3'b000;
    req_a[24 +: 8] = 8'd250; req_b[24 +: 8] = 8'd10; req_op[9 +: 3] = 3'b000;
    req_valid = 4'b1100;
    for (int i = 0; i < 6 && req_valid != 4'b0000; i++) begin
      #1;
      v = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~v;
    end
    checks++;
    if (req_valid !== 4'b0000)
      begin errors++; $display("FAIL bp_accept pending=%b want=0000", req_valid); end
    req_a[0 +: 8] = 8'd1; req_b[0 +: 8] = 8'd1; req_op[0 +: 3] = 3'b000;
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({res_valid, res_id, res_data, res_carry, res_sat} !== {1'b1, 2'd2, 8'd42, 1'b0, 1'b0})
        begin errors++; $display("FAIL bp_hold cycle=%0d got v=%b id=%0d d=%0d want v=1 id=2 d=42",
                                 i, res_valid, res_id, res_data); end
      checks++;
      if (req_ready !== 4'b0000)
        begin errors++; $display("FAIL bp_ready cycle=%0d got=%b want=0000", i, req_ready); end
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    checks++;
    if ({res_valid, res_id, res_data, res_carry, res_sat} !== {1'b1, 2'd3, 8'd4, 1'b1, 1'b0})
      begin errors++; $display("FAIL bp_second got v=%b id=%0d d=%0d c=%b want v=1 id=3 d=4 c=1",
                               res_valid, res_id, res_data, res_carry); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0)
        begin errors++; $display("FAIL bp_extra cycle=%0d got res_valid=%b want=0", i, res_valid); end
    end
  endtask

  task automatic test_flag_collision();
    bit ok;
    do_reset();
    send_one(1, 8'd100, 8'd50, 3'b110, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flag_accept got=0 want=1"); end
    sat_clr = 4'b0010;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || sat_flag[1] !== 1'b1)
      begin errors++; $display("FAIL flag_set_wins got v=%b id=%0d f=%b want v=1 id=1 f[1]=1",
                               res_valid, res_id, sat_flag); end
    tick();
    checks++;
    if (sat_flag[1] !== 1'b0)
      begin errors++; $display("FAIL flag_clear got=%b want=0", sat_flag[1]); end
    sat_clr = '0;
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    res_ready = 1'b0;
    req_a = {4{8'd100}};
    req_b = {4{8'd50}};
    req_op = {4{3'b110}};
    req_valid = 4'hF;
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b1 || sat_flag !== 4'b0001)
      begin errors++; $display("FAIL mid_fill got v=%b f=%b want v=1 f=0001", res_valid, sat_flag); end
    rst = 1'b1;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0000)
      begin errors++; $display("FAIL mid_ready_in_reset got=%b want=0000", req_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || sat_flag !== 4'b0000)
      begin errors++; $display("FAIL mid_flush got v=%b f=%b want v=0 f=0000", res_valid, sat_flag); end
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010)
      begin errors++; $display("FAIL mid_first_grant got=%b want=0010", req_ready); end
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [9:0] expq[$];
    int idq[$];
    int rr, win;
    logic [3:0] mflags, prev_clr, set;
    bit prev_s2_free;
    logic [7:0] a, b;
    logic [2:0] op;
    do_reset();
    rr = 0;
    mflags = '0;
    prev_clr = '0;
    prev_s2_free = 1'b1;
    for (int c = 0; c < 600; c++) begin
      // Account for the edge just taken.
      set = '0;
      if (prev_s2_free && res_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_unexpected cycle=%0d id=%0d d=%h", c, res_id, res_data);
        end else if (expq[0][9]) begin
          set = 4'(1 << idq[0]);
        end
      end
      mflags = (mflags & ~prev_clr) | set;
      checks++;
      if (sat_flag !== mflags)
        begin errors++; $display("FAIL rnd_flags cycle=%0d got=%b want=%b", c, sat_flag, mflags); end

      req_valid = (c < 560) ? 4'($urandom_range(0, 15)) : 4'h0;
      req_a = $urandom;
      req_b = $urandom;
      req_op = 12'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      sat_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      #1;

      if (res_valid && res_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rnd_pop_empty cycle=%0d", c);
        end else begin
          if ({res_sat, res_carry, res_data} !== expq[0] || res_id !== 2'(idq[0]))
            begin errors++; $display("FAIL rnd_result cycle=%0d got s=%b c=%b d=%h id=%0d want s=%b c=%b d=%h id=%0d",
                                     c, res_sat, res_carry, res_data, res_id,
                                     expq[0][9], expq[0][8], expq[0][7:0], idq[0]); end
          void'(expq.pop_front());
          void'(idq.pop_front());
        end
      end

      win = -1;
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && req_valid[(rr + k) % 4]) win = (rr + k) % 4;
      end
      if (req_ready != 4'b0000) begin
        checks++;
        if (win < 0 || req_ready !== 4'(1 << win)) begin
          errors++;
          $display("FAIL rnd_grant cycle=%0d valid=%b got=%b want_idx=%0d", c, req_valid,
                   req_ready, win);
        end else begin
          a = req_a[win*8 +: 8];
          b = req_b[win*8 +: 8];
          op = req_op[win*3 +: 3];
          expq.push_back(model(a, b, op));
          idq.push_back(win);
          rr = (win + 1) % 4;
        end
      end

      prev_s2_free = !res_valid || res_ready;
      prev_clr = sat_clr;
      @(posedge clk);
      #1;
    end
    checks++;
    if (expq.size() != 0)
      begin errors++; $display("FAIL rnd_drain left=%0d want=0", expq.size()); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    res_ready = 1'b1;
    sat_clr = '0;
    test_reset();
    test_signed_sat();
    test_unsigned();
    test_round_robin();
    test_backpressure();
    test_flag_collision();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
